// File: rtl/bitstream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_serializer
// Description : Captures a CFG_SIZE-bit configuration image, XORs it with a
//               repeating 32-bit keystream and emits it LSB first, one bit
//               per cycle, with back-pressure (Hold) and cancel (Abort).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                : single clock for all logic
//   rst                : synchronous, active-high reset
//   CfgIn              : plaintext configuration image (CFG_SIZE bits)
//   CfgLoad            : load request, accepted only while CfgReady=1
//   CfgReady           : high only in IDLE
//   Hold               : stalls emission in the current cycle
//   Abort              : cancels the stream in progress (wins over Hold)
//   BitStreamSerialOut : serial payload bit, 0 whenever not valid
//   BitStreamValid     : qualifies BitStreamSerialOut in the same cycle
//   BitCount           : bits emitted so far in the current stream
//   StreamDone         : one-cycle pulse after the last bit is emitted
// ============================================================================
module bitstream_serializer #(
    parameter int          CFG_SIZE    = 64,
    parameter logic [31:0] ENCRYPT_KEY = 32'hDEAD_BEEF,
    parameter int          ENCRYPT_EN  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_SIZE-1:0]           CfgIn,
    input  logic                          CfgLoad,
    output logic                          CfgReady,
    input  logic                          Hold,
    input  logic                          Abort,
    output logic                          BitStreamSerialOut,
    output logic                          BitStreamValid,
    output logic [$clog2(CFG_SIZE+1)-1:0] BitCount,
    output logic                          StreamDone
);

    localparam int c_CNT_W = $clog2(CFG_SIZE + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    // Count value while the final payload bit is on the line.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CFG_SIZE - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]          r_state_q;
    logic [1:0]          w_state_d;
    logic [CFG_SIZE-1:0] r_shift_q;
    logic [CFG_SIZE-1:0] w_shift_d;
    logic [c_CNT_W-1:0]  r_count_q;
    logic [c_CNT_W-1:0]  w_count_d;
    logic [CFG_SIZE-1:0] w_key;
    logic                w_valid;

    // Keystream: the 32-bit key repeats across the payload, wrapping when
    // CFG_SIZE is not a multiple of 32. Plaintext mode uses an all-zero key.
    for (genvar gi = 0; gi < CFG_SIZE; gi++) begin : g_key
        if (ENCRYPT_EN != 0) begin : g_enc
            assign w_key[gi] = ENCRYPT_KEY[gi % 32];
        end else begin : g_plain
            assign w_key[gi] = 1'b0;
        end
    end

    // Abort suppresses the current bit even when Hold is also asserted.
    assign w_valid            = (r_state_q == c_S_SHIFT) & ~Hold & ~Abort;
    assign BitStreamValid     = w_valid;
    assign BitStreamSerialOut = w_valid & r_shift_q[0];
    assign CfgReady           = (r_state_q == c_S_IDLE);
    assign StreamDone         = (r_state_q == c_S_DONE);
    assign BitCount           = r_count_q;

    always_comb begin
        w_state_d = r_state_q;
        w_shift_d = r_shift_q;
        w_count_d = r_count_q;
        case (r_state_q)
            c_S_IDLE: begin
                if (CfgLoad) begin
                    w_state_d = c_S_SHIFT;
                    w_shift_d = CfgIn ^ w_key;
                    w_count_d = '0;
                end
            end
            c_S_SHIFT: begin
                if (Abort) begin
                    // BitCount keeps the number of bits already sent.
                    w_state_d = c_S_IDLE;
                end else if (!Hold) begin
                    w_shift_d = {1'b0, r_shift_q[CFG_SIZE-1:1]};
                    w_count_d = r_count_q + c_CNT_ONE;
                    if (r_count_q == c_CNT_LAST) begin
                        w_state_d = c_S_DONE;
                    end
                end
            end
            c_S_DONE: begin
                w_state_d = c_S_IDLE;
            end
            default: begin
                w_state_d = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_S_IDLE;
            r_shift_q <= '0;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_shift_q <= w_shift_d;
            r_count_q <= w_count_d;
        end
    end

endmodule
`default_nettype wire
